// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table update path.
// Counters are 2-bit saturating: strongly/weakly not-taken, weakly/strongly taken.
package bp_pkg;

  localparam int BHT_IDX_W = 6;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  typedef enum logic {S_INIT, S_RUN} state_t;

  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    if (taken) return (c == ST) ? ST : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO buffering {idx, taken} branch updates from EX.
// Pointers wrap naturally because QDEPTH is a power of two.
module bht_upd_fifo #(
  parameter int QDEPTH = 4,
  parameter int WIDTH  = 7,
  localparam int AW    = $clog2(QDEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CW'(QDEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT write-port scheduler: post-reset sweep, EX update FIFO, pipelined RMW with forwarding.
// Optional BHT_UPD_STATS_EN adds update and stall counters.
module bht_update_ctrl
  import bp_pkg::*;
#(
  parameter int   IDX_W    = BHT_IDX_W,
  parameter int   QDEPTH   = 4,
  parameter ctr_t INIT_VAL = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ex_valid,
  input  logic [31:0]      i_ex_pc,
  input  logic             i_ex_taken,
  output logic             o_ex_ready,
  output logic             o_tbl_rd_en,
  output logic [IDX_W-1:0] o_tbl_rd_idx,
  input  logic [1:0]       i_tbl_rd_data,
  output logic             o_tbl_wr_en,
  output logic [IDX_W-1:0] o_tbl_wr_idx,
  output logic [1:0]       o_tbl_wr_data,
  output logic             o_init_busy,
  output logic             o_idle
`ifdef BHT_UPD_STATS_EN
  ,
  output logic [31:0]      o_stat_updates,
  output logic [31:0]      o_stat_stall_cycles
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_cnt;
  logic [CW-1:0]    fifo_count;
  logic [IDX_W:0]   fifo_din, fifo_dout;
  logic             push, pop;
  logic             w_valid, w_taken;
  logic [IDX_W-1:0] w_idx;
  logic             fwd_valid;
  logic [IDX_W-1:0] fwd_idx;
  ctr_t             fwd_data;
  ctr_t             w_old, w_new;
  logic             unused_pc;

  assign unused_pc  = ^{i_ex_pc[31:IDX_W+2], i_ex_pc[1:0]};
  assign fifo_din   = {i_ex_pc[IDX_W+1:2], i_ex_taken};
  assign o_ex_ready = rst_n && (fifo_count < CW'(QDEPTH));
  assign push       = i_ex_valid && o_ex_ready;
  assign pop        = rst_n && (state == S_RUN) && (fifo_count != '0);

  // The read-first array returns stale data when the previous write hit the same index.
  assign w_old = (fwd_valid && (fwd_idx == w_idx)) ? fwd_data : i_tbl_rd_data;
  assign w_new = sat_update(w_old, w_taken);

  bht_upd_fifo #(
    .QDEPTH (QDEPTH),
    .WIDTH  (IDX_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_valid   <= 1'b0;
      w_idx     <= '0;
      w_taken   <= 1'b0;
      fwd_valid <= 1'b0;
      fwd_idx   <= '0;
      fwd_data  <= SNT;
    end else begin
      w_valid   <= pop;
      w_idx     <= fifo_dout[IDX_W:1];
      w_taken   <= fifo_dout[0];
      fwd_valid <= w_valid;
      fwd_idx   <= w_idx;
      fwd_data  <= w_new;
    end
  end

  // Outputs are forced quiet while reset is held so an aborted operation never writes.
  always_comb begin
    state_nxt     = state;
    o_tbl_rd_en   = 1'b0;
    o_tbl_rd_idx  = '0;
    o_tbl_wr_en   = 1'b0;
    o_tbl_wr_idx  = '0;
    o_tbl_wr_data = '0;
    o_init_busy   = 1'b1;
    o_idle        = 1'b0;
    if (rst_n) begin
      case (state)
        S_INIT: begin
          o_tbl_wr_en   = 1'b1;
          o_tbl_wr_idx  = sweep_cnt;
          o_tbl_wr_data = INIT_VAL;
          if (&sweep_cnt) state_nxt = S_RUN;
        end
        S_RUN: begin
          o_init_busy  = 1'b0;
          o_tbl_rd_en  = pop;
          o_tbl_rd_idx = pop ? fifo_dout[IDX_W:1] : '0;
          if (w_valid) begin
            o_tbl_wr_en   = 1'b1;
            o_tbl_wr_idx  = w_idx;
            o_tbl_wr_data = w_new;
          end
          o_idle = (fifo_count == '0) && !w_valid;
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end

`ifdef BHT_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_stat_updates      <= '0;
      o_stat_stall_cycles <= '0;
    end else begin
      if (w_valid) o_stat_updates <= o_stat_updates + 32'd1;
      if (i_ex_valid && !o_ex_ready) o_stat_stall_cycles <= o_stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl: directed scenarios plus random updates
// checked against a queue-and-array model of the counter table.
module tb_bht_update_ctrl;

  localparam int IDX_W   = 6;
  localparam int ENTRIES = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_ex_valid;
  logic [31:0]      i_ex_pc;
  logic             i_ex_taken;
  logic             o_ex_ready;
  logic             o_tbl_rd_en;
  logic [IDX_W-1:0] o_tbl_rd_idx;
  logic [1:0]       i_tbl_rd_data;
  logic             o_tbl_wr_en;
  logic [IDX_W-1:0] o_tbl_wr_idx;
  logic [1:0]       o_tbl_wr_data;
  logic             o_init_busy;
  logic             o_idle;

  always #5 clk = ~clk;

  bht_update_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ex_valid    (i_ex_valid),
    .i_ex_pc       (i_ex_pc),
    .i_ex_taken    (i_ex_taken),
    .o_ex_ready    (o_ex_ready),
    .o_tbl_rd_en   (o_tbl_rd_en),
    .o_tbl_rd_idx  (o_tbl_rd_idx),
    .i_tbl_rd_data (i_tbl_rd_data),
    .o_tbl_wr_en   (o_tbl_wr_en),
    .o_tbl_wr_idx  (o_tbl_wr_idx),
    .o_tbl_wr_data (o_tbl_wr_data),
    .o_init_busy   (o_init_busy),
    .o_idle        (o_idle)
  );

  // Read-first single-port-each array the controller drives.
  logic [1:0] mem [ENTRIES];
  always @(posedge clk) begin
    if (o_tbl_rd_en) i_tbl_rd_data <= mem[o_tbl_rd_idx];
    if (o_tbl_wr_en) mem[o_tbl_wr_idx] <= o_tbl_wr_data;
  end

  typedef struct { int idx; int taken; } upd_t;
  upd_t expq[$];
  int   refv [ENTRIES];
  int   sweep_idx;
  int   errors;
  int   checks;
  int   rmw_writes;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every write is either the next sweep entry or the oldest accepted update.
  task automatic serviceWrite();
    upd_t u;
    int   e;
    if (o_tbl_wr_en === 1'b1) begin
      if (o_init_busy === 1'b1) begin
        checkOutput("sweep_idx", 32'(o_tbl_wr_idx), sweep_idx);
        checkOutput("sweep_data", 32'(o_tbl_wr_data), 1);
        if (sweep_idx < ENTRIES) refv[sweep_idx] = 1;
        sweep_idx++;
      end else if (expq.size() == 0) begin
        checkOutput("unexpected_wr_en", 32'(o_tbl_wr_en), 0);
      end else begin
        u = expq.pop_front();
        e = refv[u.idx] + (u.taken != 0 ? 1 : -1);
        if (e > 3) e = 3;
        if (e < 0) e = 0;
        refv[u.idx] = e;
        rmw_writes++;
        checkOutput("rmw_idx", 32'(o_tbl_wr_idx), u.idx);
        checkOutput("rmw_data", 32'(o_tbl_wr_data), e);
      end
    end
  endtask

  // One cycle: drive after the edge, sample shortly after, log an accepted push.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] pc,
                               input logic t, output logic acc);
    upd_t u;
    @(posedge clk);
    #1;
    rst_n      = r;
    i_ex_valid = v;
    i_ex_pc    = pc;
    i_ex_taken = t;
    if (!r) begin
      expq.delete();
      sweep_idx = 0;
    end
    #1;
    serviceWrite();
    acc = v && (o_ex_ready === 1'b1);
    if (acc) begin
      u.idx   = int'((pc >> 2) % ENTRIES);
      u.taken = int'(t);
      expq.push_back(u);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    logic acc;
    bit   done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
      if (o_idle === 1'b1 && expq.size() == 0) done = 1;
    end
    checkOutput({tag, "_idle"}, 32'(o_idle), 1);
    checkOutput({tag, "_queue_empty"}, expq.size(), 0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] pc;
    int          idx;
    int          pops;
    int          base;
    bit          got;
    logic [31:0] t4_pc [4];
    logic        t4_tk [4];

    errors = 0; checks = 0; rmw_writes = 0; sweep_idx = 0;
    rst_n = 1'b0; i_ex_valid = 1'b0; i_ex_pc = '0; i_ex_taken = 1'b0;

    // Reset values
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("rst_init_busy", 32'(o_init_busy), 1);
    checkOutput("rst_ex_ready", 32'(o_ex_ready), 0);
    checkOutput("rst_idle", 32'(o_idle), 0);
    checkOutput("rst_rd_en", 32'(o_tbl_rd_en), 0);
    checkOutput("rst_rd_idx", 32'(o_tbl_rd_idx), 0);
    checkOutput("rst_wr_en", 32'(o_tbl_wr_en), 0);
    checkOutput("rst_wr_idx", 32'(o_tbl_wr_idx), 0);
    checkOutput("rst_wr_data", 32'(o_tbl_wr_data), 0);

    // Sweep: one write per cycle, idx 0..63
    for (int k = 0; k < ENTRIES; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
      checkOutput("sweep_wr_en", 32'(o_tbl_wr_en), 1);
      checkOutput("sweep_busy", 32'(o_init_busy), 1);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("sweep_done_busy", 32'(o_init_busy), 0);
    checkOutput("sweep_done_wr_en", 32'(o_tbl_wr_en), 0);
    checkOutput("sweep_count", sweep_idx, ENTRIES);
    checkOutput("run_idle", 32'(o_idle), 1);
    repeat (4) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
      checkOutput("quiet_wr_en", 32'(o_tbl_wr_en), 0);
    end

    // Latency: push at t, read at t+1, write at t+2
    applyStimulus(1'b1, 1'b1, 32'h0000_0104, 1'b1, acc);
    checkOutput("lat_accept", 32'(acc), 1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("lat_rd_en", 32'(o_tbl_rd_en), 1);
    checkOutput("lat_rd_idx", 32'(o_tbl_rd_idx), 1);
    checkOutput("lat_wr_en_early", 32'(o_tbl_wr_en), 0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("lat_wr_en", 32'(o_tbl_wr_en), 1);
    checkOutput("lat_wr_idx", 32'(o_tbl_wr_idx), 1);
    checkOutput("lat_wr_data", 32'(o_tbl_wr_data), 2);

    // Back-to-back same index exercises forwarding
    repeat (3) applyStimulus(1'b1, 1'b1, 32'h0000_000C, 1'b1, acc);
    drain("fwd", 10);
    checkOutput("fwd_final", refv[3], 3);

    // Saturation at both ends on idx 5
    repeat (3) applyStimulus(1'b1, 1'b1, 32'h0000_0014, 1'b0, acc);
    repeat (4) applyStimulus(1'b1, 1'b1, 32'h0000_0014, 1'b1, acc);
    drain("sat", 10);
    checkOutput("sat_final", refv[5], 3);

    // Random updates, biased toward a few indices
    for (int i = 0; i < 300; i++) begin
      idx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      pc  = ($urandom & ~32'h0000_00FC) | (32'(idx) << 2);
      applyStimulus(1'b1, $urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)), acc);
    end
    drain("rand", 20);

    // Pushes during the sweep fill the FIFO; a held 5th enters after the first pop
    t4_pc[0] = 32'h0000_0008; t4_tk[0] = 1'b1;
    t4_pc[1] = 32'h0000_0008; t4_tk[1] = 1'b1;
    t4_pc[2] = 32'h0000_0010; t4_tk[2] = 1'b0;
    t4_pc[3] = 32'h0000_0008; t4_tk[3] = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("rst2_ex_ready", 32'(o_ex_ready), 0);
    base = rmw_writes;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 1'b1, t4_pc[j], t4_tk[j], acc);
      checkOutput("init_push_accept", 32'(acc), 1);
    end
    applyStimulus(1'b1, 1'b1, 32'h0000_0024, 1'b1, acc);
    checkOutput("full_ready_low", 32'(o_ex_ready), 0);
    pops = 0;
    got  = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      applyStimulus(1'b1, 1'b1, 32'h0000_0024, 1'b1, acc);
      if (acc) begin
        checkOutput("accept_after_first_pop", pops, 1);
        got = 1;
      end else begin
        pops += int'(o_tbl_rd_en);
      end
    end
    if (!got) checkOutput("accept_timeout", 32'(got), 1);
    drain("fill", 100);
    checkOutput("fill_writes", rmw_writes - base, 5);
    checkOutput("fill_sweep_count", sweep_idx, ENTRIES);

    // Reset mid-sweep at idx 20 with two updates queued
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, acc);
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b1, k >= 18, 32'h0000_0028, 1'b1, acc);
    checkOutput("pre_abort_wr_idx", 32'(o_tbl_wr_idx), 19);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("abort_wr_en", 32'(o_tbl_wr_en), 0);
    checkOutput("abort_busy", 32'(o_init_busy), 1);
    base = rmw_writes;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("restart_wr_idx", 32'(o_tbl_wr_idx), 0);
    repeat (79) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, acc);
    checkOutput("restart_sweep_count", sweep_idx, ENTRIES);
    checkOutput("discarded_updates", rmw_writes - base, 0);
    checkOutput("restart_idle", 32'(o_idle), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
